// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, funct codes,
// control FSM states and ALU operations.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_LUI,
    ALU_SLL,
    ALU_SRL
  } alu_op_t;

  function automatic logic [XLEN-1:0] sext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_regfile.sv
// Architectural register file: NUM_REGS entries, two asynchronous read ports,
// one synchronous write port. $0 reads zero; out-of-range indices read zero
// and writes to them are dropped.
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset (clears all entries)
//   i_raddr_a/o_rdata_a     read port A
//   i_raddr_b/o_rdata_b     read port B
//   i_we, i_waddr, i_wdata  write port, commits on rising edge
module mips_regfile
  import mips_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [4:0]      i_raddr_a,
  output logic [XLEN-1:0] o_rdata_a,
  input  logic [4:0]      i_raddr_b,
  output logic [XLEN-1:0] o_rdata_b,
  input  logic            i_we,
  input  logic [4:0]      i_waddr,
  input  logic [XLEN-1:0] i_wdata
);

  localparam int unsigned AW    = $clog2(NUM_REGS);
  localparam logic [5:0]  LIMIT = 6'(NUM_REGS);

  logic [XLEN-1:0] r_regs [NUM_REGS];
  logic            w_rd_a_ok;
  logic            w_rd_b_ok;
  logic            w_wr_ok;

  // Index 0 and indices beyond the implemented depth are not backed by storage
  assign w_rd_a_ok = (i_raddr_a != 5'd0) && ({1'b0, i_raddr_a} < LIMIT);
  assign w_rd_b_ok = (i_raddr_b != 5'd0) && ({1'b0, i_raddr_b} < LIMIT);
  assign w_wr_ok   = (i_waddr   != 5'd0) && ({1'b0, i_waddr}   < LIMIT);

  assign o_rdata_a = w_rd_a_ok ? r_regs[i_raddr_a[AW-1:0]] : '0;
  assign o_rdata_b = w_rd_b_ok ? r_regs[i_raddr_b[AW-1:0]] : '0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && w_wr_ok) begin
      r_regs[i_waddr[AW-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/mips_multicycle_core.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB control FSM sharing one
// request/ready memory port for instruction fetch and data access.
// Optional macro MIPS_MC_SHIFT_EN adds sll/srl (funct 00/02); otherwise
// those encodings halt the core.
// Ports:
//   clock, reset_n                 clock, async active-low reset
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_ready/mem_rdata  memory port (handshake = req && ready)
//   halted                         core is in HALT
//   pc_out, instr_out, alu_result,
//   zero_flag, reg_write_data,
//   reg_write_en                   debug observation
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NUM_REGS = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        halted,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out,
  output logic [31:0] alu_result,
  output logic        zero_flag,
  output logic [31:0] reg_write_data,
  output logic        reg_write_en
);

  state_t          r_state;
  state_t          w_state_nx;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_ir;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_alu;
  logic [XLEN-1:0] r_wdata;
  logic            r_wen;
  logic [4:0]      r_wdest;

  logic [5:0]      w_opcode;
  logic [5:0]      w_funct;
  logic [XLEN-1:0] w_imm_sext;
  logic [XLEN-1:0] w_rs_data;
  logic [XLEN-1:0] w_rt_data;
  logic [XLEN-1:0] w_opb;
  logic [XLEN-1:0] w_alu_y;
  alu_op_t         w_alu_op;
  logic            w_use_imm;
  logic            w_legal;
  logic [4:0]      w_dest;
  logic            w_is_j;
  logic            w_is_beq;
  logic            w_is_lw;
  logic            w_is_sw;
  logic            w_hs;

  assign w_opcode   = r_ir[31:26];
  assign w_funct    = r_ir[5:0];
  assign w_imm_sext = sext16(r_ir[15:0]);
  assign w_is_j     = (w_opcode == OP_J);
  assign w_is_beq   = (w_opcode == OP_BEQ);
  assign w_is_lw    = (w_opcode == OP_LW);
  assign w_is_sw    = (w_opcode == OP_SW);
  assign w_hs       = mem_req && mem_ready;

  mips_regfile #(
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .i_clk     (clock),
    .i_rst_n   (reset_n),
    .i_raddr_a (r_ir[25:21]),
    .o_rdata_a (w_rs_data),
    .i_raddr_b (r_ir[20:16]),
    .o_rdata_b (w_rt_data),
    .i_we      (r_wen),
    .i_waddr   (r_wdest),
    .i_wdata   (r_wdata)
  );

  // Instruction decode: legality, ALU operation, operand source, destination
  always_comb begin
    w_alu_op  = ALU_ADD;
    w_use_imm = 1'b0;
    w_legal   = 1'b0;
    w_dest    = r_ir[20:16];
    case (w_opcode)
      OP_RTYPE: begin
        w_dest = r_ir[15:11];
        case (w_funct)
          FN_ADD: begin w_legal = 1'b1; w_alu_op = ALU_ADD; end
          FN_SUB: begin w_legal = 1'b1; w_alu_op = ALU_SUB; end
          FN_AND: begin w_legal = 1'b1; w_alu_op = ALU_AND; end
          FN_OR:  begin w_legal = 1'b1; w_alu_op = ALU_OR;  end
          FN_SLT: begin w_legal = 1'b1; w_alu_op = ALU_SLT; end
`ifdef MIPS_MC_SHIFT_EN
          FN_SLL: begin w_legal = 1'b1; w_alu_op = ALU_SLL; end
          FN_SRL: begin w_legal = 1'b1; w_alu_op = ALU_SRL; end
`else
          FN_SLL, FN_SRL: w_legal = 1'b0;
`endif
          default: w_legal = 1'b0;
        endcase
      end
      OP_ADDI:      begin w_legal = 1'b1; w_use_imm = 1'b1; w_alu_op = ALU_ADD; end
      OP_LUI:       begin w_legal = 1'b1; w_alu_op = ALU_LUI; end
      OP_LW, OP_SW: begin w_legal = 1'b1; w_use_imm = 1'b1; w_alu_op = ALU_ADD; end
      OP_BEQ:       begin w_legal = 1'b1; w_alu_op = ALU_SUB; end
      OP_J:         w_legal = 1'b1;
      default:      w_legal = 1'b0;
    endcase
  end

  // ALU; shifts act on rt by shamt
  assign w_opb = w_use_imm ? w_imm_sext : r_b;

  always_comb begin
    w_alu_y = '0;
    case (w_alu_op)
      ALU_ADD: w_alu_y = r_a + w_opb;
      ALU_SUB: w_alu_y = r_a - w_opb;
      ALU_AND: w_alu_y = r_a & w_opb;
      ALU_OR:  w_alu_y = r_a | w_opb;
      ALU_SLT: w_alu_y = {31'd0, $signed(r_a) < $signed(w_opb)};
      ALU_LUI: w_alu_y = {r_ir[15:0], 16'h0000};
      ALU_SLL: w_alu_y = r_b << r_ir[10:6];
      ALU_SRL: w_alu_y = r_b >> r_ir[10:6];
      default: w_alu_y = '0;
    endcase
  end

  // Control FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next state and memory-port drive; request is gated by reset so it drops
  // the moment reset is asserted, even mid-handshake
  always_comb begin
    w_state_nx = r_state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = {r_pc[31:2], 2'b00};
    case (r_state)
      FETCH: begin
        mem_req = reset_n;
        if (mem_ready) w_state_nx = DECODE;
      end
      DECODE: begin
        if (!w_legal)    w_state_nx = HALT;
        else if (w_is_j) w_state_nx = FETCH;
        else             w_state_nx = EXEC;
      end
      EXEC: begin
        if (w_is_beq)                w_state_nx = FETCH;
        else if (w_is_lw || w_is_sw) w_state_nx = MEM;
        else                         w_state_nx = WB;
      end
      MEM: begin
        mem_req  = reset_n;
        mem_we   = reset_n && w_is_sw;
        mem_addr = {r_alu[31:2], 2'b00};
        if (mem_ready) w_state_nx = w_is_lw ? WB : FETCH;
      end
      WB:      w_state_nx = FETCH;
      HALT:    w_state_nx = HALT;
      default: w_state_nx = HALT;
    endcase
  end

  // Datapath registers; r_wen is raised for exactly the WB cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_alu   <= '0;
      r_wdata <= '0;
      r_wen   <= 1'b0;
      r_wdest <= '0;
    end else begin
      r_wen <= 1'b0;
      case (r_state)
        FETCH: begin
          if (w_hs) begin
            r_ir <= mem_rdata;
            r_pc <= r_pc + 32'd4;
          end
        end
        DECODE: begin
          r_a <= w_rs_data;
          r_b <= w_rt_data;
          if (w_legal && w_is_j) r_pc <= {r_pc[31:28], r_ir[25:0], 2'b00};
        end
        EXEC: begin
          r_alu <= w_alu_y;
          if (w_is_beq && (r_a == r_b)) r_pc <= r_pc + {w_imm_sext[29:0], 2'b00};
          if (w_state_nx == WB) begin
            r_wen   <= 1'b1;
            r_wdata <= w_alu_y;
            r_wdest <= w_dest;
          end
        end
        MEM: begin
          if (w_hs && w_is_lw) begin
            r_wen   <= 1'b1;
            r_wdata <= mem_rdata;
            r_wdest <= w_dest;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_wdata      = r_b;
  assign halted         = (r_state == HALT);
  assign pc_out         = r_pc;
  assign instr_out      = r_ir;
  assign alu_result     = r_alu;
  assign zero_flag      = (r_alu == '0);
  assign reg_write_data = r_wdata;
  assign reg_write_en   = r_wen;

endmodule

// File: tb/tb_mips_multicycle_core.sv
// Self-checking bench for mips_multicycle_core (RESET_PC=0x40, NUM_REGS=8).
// Expected write-backs and stores are queued when a program is loaded and
// popped by a monitor as the core produces them, with data and cycle number.
// Honours MIPS_MC_SHIFT_EN for the shift-instruction expectations.
module tb_mips_multicycle_core;

  localparam logic [31:0] RST_PC = 32'h0000_0040;
`ifdef MIPS_MC_SHIFT_EN
  localparam int          HALT_CYC = 89;
  localparam logic [31:0] HALT_PC  = 32'h0000_00A0;
`else
  localparam int          HALT_CYC = 77;
  localparam logic [31:0] HALT_PC  = 32'h0000_0094;
`endif

  logic        clock;
  logic        reset_n;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        halted;
  logic [31:0] pc_out;
  logic [31:0] instr_out;
  logic [31:0] alu_result;
  logic        zero_flag;
  logic [31:0] reg_write_data;
  logic        reg_write_en;

  mips_multicycle_core #(
    .RESET_PC (RST_PC),
    .NUM_REGS (8)
  ) u_dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_wdata      (mem_wdata),
    .mem_ready      (mem_ready),
    .mem_rdata      (mem_rdata),
    .halted         (halted),
    .pc_out         (pc_out),
    .instr_out      (instr_out),
    .alu_result     (alu_result),
    .zero_flag      (zero_flag),
    .reg_write_data (reg_write_data),
    .reg_write_en   (reg_write_en)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // 64-word memory with programmable wait states before every handshake
  logic [31:0] mem [64];
  logic [31:0] img [64];
  logic        ld_en;
  logic [5:0]  ld_idx;
  logic [31:0] ld_data;
  int unsigned stall_cfg;
  int unsigned stall_cnt;
  int          cyc;
  int          n_tests;
  int          n_fail;

  typedef struct {
    bit          st;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } ev_t;
  ev_t sb_q[$];

  assign mem_ready = mem_req && (stall_cnt >= stall_cfg);
  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n)                  stall_cnt <= 0;
    else if (mem_req && !mem_ready) stall_cnt <= stall_cnt + 1;
    else                           stall_cnt <= 0;
  end

  always @(posedge clock) begin
    if (ld_en) mem[ld_idx] <= ld_data;
    else if (mem_req && mem_ready && mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  // cycle 1 is the first cycle after reset release
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 1;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic exp_wb(input logic [31:0] data, input int c);
    ev_t e;
    e.st = 1'b0; e.addr = '0; e.data = data; e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic exp_st(input logic [31:0] addr, input logic [31:0] data, input int c);
    ev_t e;
    e.st = 1'b1; e.addr = addr; e.data = data; e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic sb_check(input bit st, input logic [31:0] addr, input logic [31:0] data);
    ev_t e;
    if (sb_q.size() == 0) begin
      chk(st ? "sb_unexpected_store" : "sb_unexpected_wb", 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk("sb_kind", 32'(st), 32'(e.st));
    if (st) chk("st_addr", addr, e.addr);
    chk(st ? "st_data" : "wb_data", data, e.data);
    chk("ev_cycle", 32'(cyc), 32'(e.cyc));
  endtask

  // Monitor: scoreboard pops plus stability of a stalled request
  logic        prev_wait;
  logic [31:0] prev_addr;
  logic [31:0] prev_wdata;
  logic        prev_we;

  always @(negedge clock) begin
    if (!reset_n) begin
      prev_wait = 1'b0;
    end else begin
      if (prev_wait) begin
        chk("hold_req",   32'(mem_req), 32'd1);
        chk("hold_addr",  mem_addr,     prev_addr);
        chk("hold_we",    32'(mem_we),  32'(prev_we));
        chk("hold_wdata", mem_wdata,    prev_wdata);
      end
      prev_wait  = mem_req && !mem_ready;
      prev_addr  = mem_addr;
      prev_we    = mem_we;
      prev_wdata = mem_wdata;
      if (reg_write_en) sb_check(1'b0, 32'd0, reg_write_data);
      if (mem_req && mem_ready && mem_we) sb_check(1'b1, mem_addr, mem_wdata);
    end
  end

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = 32'h0;
  endtask

  // Hold reset, load the image, check reset values, release, check cycle 1
  task automatic start_phase();
    reset_n = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      ld_en = 1'b1; ld_idx = 6'(i); ld_data = img[i];
    end
    @(negedge clock);
    ld_en = 1'b0;
    #1;
    chk("rst_req",   32'(mem_req),      32'd0);
    chk("rst_we",    32'(mem_we),       32'd0);
    chk("rst_halt",  32'(halted),       32'd0);
    chk("rst_pc",    pc_out,            RST_PC);
    chk("rst_ir",    instr_out,         32'd0);
    chk("rst_alu",   alu_result,        32'd0);
    chk("rst_zero",  32'(zero_flag),    32'd1);
    chk("rst_wdata", reg_write_data,    32'd0);
    chk("rst_wen",   32'(reg_write_en), 32'd0);
    @(negedge clock);
    #2;
    reset_n = 1'b1;
    #1;
    chk("c1_req",  32'(mem_req), 32'd1);
    chk("c1_addr", mem_addr,     RST_PC);
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc != target && n < 500) begin
      @(negedge clock); #1; n++;
    end
    chk("reach_cycle", 32'(cyc), 32'(target));
  endtask

  task automatic wait_halt(input int budget, output int at_cyc);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clock); #1; n++;
    end
    at_cyc = halted ? cyc : -1;
  endtask

  initial begin
    int hc;
    n_tests = 0; n_fail = 0;
    reset_n = 1'b0; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
    stall_cfg = 0;

    // Program A: ALU, memory, register-depth, $0, branch, jump, shifts
    clear_img();
    img[16] = 32'h3C01_0003;  exp_wb(32'h0003_0000, 4);   // lui $1,3
    img[17] = 32'h3C01_0000;  exp_wb(32'h0,         8);   // lui $1,0
    img[18] = 32'h2021_0003;  exp_wb(32'd3,         12);  // addi $1,$1,3
    img[19] = 32'h2002_0005;  exp_wb(32'd5,         16);  // addi $2,$0,5
    img[20] = 32'h0022_1820;  exp_wb(32'd8,         20);  // add $3,$1,$2
    img[21] = 32'hAC03_0008;  exp_st(32'd8, 32'd8,  24);  // sw $3,8($0)
    img[22] = 32'h8C04_0008;  exp_wb(32'd8,         29);  // lw $4,8($0)
    img[23] = 32'h0041_2822;  exp_wb(32'd2,         33);  // sub $5,$2,$1
    img[24] = 32'h0041_302A;  exp_wb(32'd0,         37);  // slt $6,$2,$1
    img[25] = 32'h2007_FFFF;  exp_wb(32'hFFFF_FFFF, 41);  // addi $7,$0,-1
    img[26] = 32'h00E1_302A;  exp_wb(32'd1,         45);  // slt $6,$7,$1
    img[27] = 32'h00E3_2824;  exp_wb(32'd8,         49);  // and $5,$7,$3
    img[28] = 32'h0022_2825;  exp_wb(32'd7,         53);  // or $5,$1,$2
    img[29] = 32'h200C_0055;  exp_wb(32'h55,        57);  // addi $12,$0,0x55
    img[30] = 32'hAC0C_000C;  exp_st(32'd12, 32'd0, 61);  // sw $12,12($0)
    img[31] = 32'h2000_0007;  exp_wb(32'd7,         65);  // addi $0,$0,7
    img[32] = 32'hAC00_0010;  exp_st(32'd16, 32'd0, 69);  // sw $0,16($0)
    img[33] = 32'h1022_0005;                              // beq $1,$2,+5
    img[34] = 32'h0800_0024;                              // j 0x90
    img[35] = 32'hFC00_0000;                              // skipped by j
    img[36] = 32'h0001_2900;                              // sll $5,$1,4
    img[37] = 32'h0005_3082;                              // srl $6,$5,2
    img[38] = 32'h0000_0000;                              // nop
    img[39] = 32'hFC00_0000;                              // illegal
`ifdef MIPS_MC_SHIFT_EN
    exp_wb(32'd48, 78);
    exp_wb(32'd12, 82);
    exp_wb(32'd0,  86);
`endif
    start_phase();
    wait_halt(300, hc);
    chk("halt_cycle", 32'(hc), 32'(HALT_CYC));
    chk("halt_pc",    pc_out, HALT_PC);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock); #1;
      chk("halt_req", 32'(mem_req), 32'd0);
      chk("halt_hold", 32'(halted), 32'd1);
    end
    chk("a_sb_empty", 32'(sb_q.size()), 32'd0);
    chk("mem_word2",  mem[2], 32'd8);

    // Program B: beq $0,$0,-1 loops on itself every 3 cycles
    clear_img();
    img[16] = 32'h1000_FFFF;
    start_phase();
    for (int k = 1; k <= 3; k++) begin
      wait_cyc(3 * k - 1);
      chk("loop_pc_fetched", pc_out, 32'h44);
      wait_cyc(3 * k + 1);
      chk("loop_pc",   pc_out,          32'h40);
      chk("loop_addr", mem_addr,        32'h40);
      chk("loop_req",  32'(mem_req),    32'd1);
      chk("loop_zero", 32'(zero_flag),  32'd1);
      chk("loop_ir",   instr_out,       32'h1000_FFFF);
    end
    chk("b_sb_empty", 32'(sb_q.size()), 32'd0);

    // Program C: 3 wait states per transfer, then reset mid-fetch
    clear_img();
    stall_cfg = 3;
    img[2]  = 32'h1234_5678;
    img[16] = 32'h8C01_0008;  exp_wb(32'h1234_5678, 11);  // lw $1,8($0)
    img[17] = 32'h2002_0001;                              // addi $2,$0,1
    start_phase();
    wait_cyc(11);
    chk("lw_wen", 32'(reg_write_en), 32'd1);
    wait_cyc(13);
    chk("stall_req",   32'(mem_req),   32'd1);
    chk("stall_ready", 32'(mem_ready), 32'd0);
    chk("stall_addr",  mem_addr,       32'h44);
    chk("stall_pc",    pc_out,         32'h44);
    reset_n = 1'b0;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_pc",  pc_out,       RST_PC);
    chk("midrst_ir",  instr_out,    32'd0);
    chk("c_sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

- Multi-cycle MIPS core with a five-phase control FSM: fetch, decode, execute, memory, write-back.
- Reaches instruction and data storage through a single request/ready memory port, so it works with memories of any latency.
- Register-file depth and reset vector are set by parameters.
- Sits at processor top level as the successor to the single-cycle datapath, and keeps the same debug observation outputs.

## Interface

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NUM_REGS, 32: number of architectural registers; legal range 8..32, power of two.
  - Reads of index ≥ NUM_REGS return 0.
  - Writes to index ≥ NUM_REGS are dropped.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- mem_req  out  1  memory transfer request
- mem_we  out  1  1 = store, 0 = load/fetch
- mem_addr  out  32  word-aligned byte address; bits [1:0] are always 0
- mem_wdata  out  32  store data
- mem_ready  in  1  transfer completes when mem_req && mem_ready; may be combinational
- mem_rdata  in  32  load/fetch data, valid when mem_ready
- halted  out  1  core is in HALT
- pc_out  out  32  current PC
- instr_out  out  32  instruction register
- alu_result  out  32  ALU output register
- zero_flag  out  1  ALU result == 0
- reg_write_data  out  32  write-back data
- reg_write_en  out  1  register write strobe, one cycle per write

## Operation

Supported instructions:
- R-type: add, sub, and, or, slt (funct 20/22/24/25/2A).
- I-type: addi (08), lui (0F), lw (23), sw (2B), beq (04).
- J-type: j (02).
- Any other opcode or funct → HALT.

FSM transitions:
- FETCH: mem_req=1, mem_addr=PC. On handshake, the IR is loaded and PC ← PC+4.
- DECODE: reads rs/rt into A/B. j sets PC ← {PC[31:28], IR[25:0], 2'b00} and goes to FETCH. An illegal instruction goes to HALT.
- EXEC: the ALU computes. beq sets PC ← PC + (sext(imm)<<2) if A==B, then goes to FETCH. lw/sw go to MEM; others go to WB.
- MEM: mem_req=1, mem_addr = ALU result with [1:0] cleared. On handshake, sw goes to FETCH and lw latches MDR, then goes to WB.
- WB: a single-cycle write of rd (R-type) or rt (I-type), then FETCH.
- HALT: terminal until reset; mem_req=0.

Datapath rules:
- Register $0 reads 0; writes to it are ignored, but the reg_write_en pulse still occurs.
- Immediates: addi/lw/sw/beq are sign-extended; lui produces {imm, 16'h0}.
- Arithmetic wraps modulo 2^32; there are no overflow exceptions.
- slt is a signed compare.

Reset:
- Asynchronous. Takes effect immediately in any state, including mid-handshake; mem_req drops at once.
- Reset values:
  - PC = RESET_PC; IR, alu_result and reg_write_data = 0.
  - mem_req, mem_we, reg_write_en and halted = 0.
  - zero_flag = 1.
  - All registers = 0.

## Timing

- Cycle counts with zero-wait memory: j 2, beq 3, R-type/addi/lui 4, sw 4, lw 5.
- Each memory wait cycle extends FETCH or MEM by one cycle.
- While waiting, mem_addr, mem_we and mem_wdata are held stable.
- mem_req is never deasserted before its handshake, except on reset.
- The register-file write commits on the clock edge that leaves WB.
- pc_out updates on the edge that ends FETCH, or on the edge that ends DECODE/EXEC for j/beq.

## Configuration

- MIPS_MC_SHIFT_EN defined: adds sll (funct 00) and srl (funct 02), which shift rt by shamt (IR[10:6]) and write rd in 4 cycles.
  - The all-zero instruction (sll $0,$0,0) is then a NOP.
- MIPS_MC_SHIFT_EN undefined: funct 00/02 are illegal and go to HALT.

## Structure

- Shared package mips_pkg holds:
  - opcode and funct localparams;
  - the FSM state enum: FETCH, DECODE, EXEC, MEM, WB, HALT;
  - the ALU operation enum.
- One sub-module, mips_regfile: NUM_REGS entries, two asynchronous read ports, one synchronous write port, $0 hardwired to zero, asynchronous reset.
- The ALU and control FSM are inline in the top module.

## Test plan

- Reset release with RESET_PC=32'h40, zero-wait memory → first mem_req with mem_addr=32'h40 in the first cycle; lui $1,0x0003 → after 4 cycles reg_write_data=32'h0003_0000 and reg_write_en pulses once.
- Program: lui $1,0; addi $1,$1,3; addi $2,$0,5; add $3,$1,$2; sw $3,8($0); lw $4,8($0) → memory word 2 = 8, $4 = 8; total cycles 4+4+4+4+4+5 = 25.
- beq $0,$0,-1 → PC returns to the same address every 3 cycles, zero_flag=1; beq with unequal operands falls through to PC+4.
- mem_ready held low for 3 cycles during FETCH and during MEM of lw → mem_req/mem_addr stay stable throughout; lw completes in 5+6 = 11 cycles.
- Illegal opcode 6'h3F → halted=1 after DECODE, mem_req stays 0; reset_n pulse mid-FETCH with mem_req=1 → mem_req=0 immediately, PC=RESET_PC.
- With MIPS_MC_SHIFT_EN: sll $5,$1,4 where $1=3 → $5=48; without the macro the same word → halted=1; NUM_REGS=8 write to $12 is dropped and reads of $12 return 0.
